// File: rtl/router_sync_nx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_sync_nx                                                             |
// | Destination latch, write-enable steering, per-FIFO valid and timeout flush |
// | for NUM_CH output FIFOs. Optional ROUTER_SYNC_TO_STATUS_EN: sticky status. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module router_sync_nx #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = $clog2(NUM_CH),
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
`ifdef ROUTER_SYNC_TO_STATUS_EN
  input  logic [NUM_CH-1:0] to_clr,
  output logic [NUM_CH-1:0] to_status,
`endif
  output logic [NUM_CH-1:0] vld_out,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  localparam int         c_sel_w    = 1 << ADDR_W;
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  logic [ADDR_W-1:0]  r_addr;
  logic               r_addr_err;
  logic               w_addr_bad;
  logic [c_sel_w-1:0] w_full_ext;
  logic [NUM_CH-1:0]  w_onehot;

  // Only a non-power-of-two channel count can be addressed out of range.
  generate
    if (NUM_CH == c_sel_w) begin : g_addr_pow2
      assign w_addr_bad = 1'b0;
    end else begin : g_addr_range
      assign w_addr_bad = ({1'b0, data_in} >= (ADDR_W + 1)'(NUM_CH));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_addr_err <= 1'b0;
    end else if (detect_add) begin
      r_addr     <= data_in;
      r_addr_err <= w_addr_bad;
    end
  end

  assign w_full_ext = c_sel_w'(full);
  assign w_onehot   = NUM_CH'(1) << r_addr;

  // A bad destination reports full so the FSM stalls instead of dropping data.
  assign fifo_full  = r_addr_err | w_full_ext[r_addr];
  assign write_enb  = (write_enb_reg && !r_addr_err) ? w_onehot : '0;
  assign vld_out    = ~empty;
  assign addr_err   = r_addr_err;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [7:0] r_cnt;
      logic       r_soft;
      logic       w_idle;
      logic       w_expire;

      assign w_idle   = vld_out[i] & ~read_enb[i];
      assign w_expire = w_idle && (r_cnt == c_cnt_last);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_cnt  <= '0;
          r_soft <= 1'b0;
        end else begin
          r_soft <= w_expire;
          if (!w_idle || w_expire) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end

      assign soft_reset[i] = r_soft;

`ifdef ROUTER_SYNC_TO_STATUS_EN
      logic r_stat;

      // A set on the expiry edge takes priority over a simultaneous clear.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_stat <= 1'b0;
        end else if (w_expire) begin
          r_stat <= 1'b1;
        end else if (to_clr[i]) begin
          r_stat <= 1'b0;
        end
      end

      assign to_status[i] = r_stat;
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_router_sync_nx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_router_sync_nx                                                          |
// | Scoreboard bench for router_sync_nx (NUM_CH=4 and NUM_CH=3 instances).     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_router_sync_nx;

  logic       clk = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [3:0] read_enb, full, empty, to_clr;
  logic [3:0] vld_out, write_enb, soft_reset, to_status;
  logic       fifo_full, addr_err;
  logic [2:0] vld_out3, write_enb3, soft_reset3, to_status3;
  logic       fifo_full3, addr_err3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       nm;
  } chk_t;

  chk_t sb_q[$];
  int   pulse_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  router_sync_nx #(.NUM_CH(4), .TIMEOUT(30)) dut (
    .clk(clk), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .full(full), .empty(empty),
`ifdef ROUTER_SYNC_TO_STATUS_EN
    .to_clr(to_clr), .to_status(to_status),
`endif
    .vld_out(vld_out), .fifo_full(fifo_full), .write_enb(write_enb),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  router_sync_nx #(.NUM_CH(3), .TIMEOUT(30)) dut3 (
    .clk(clk), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb[2:0]), .full(full[2:0]),
    .empty(3'b111),
`ifdef ROUTER_SYNC_TO_STATUS_EN
    .to_clr(to_clr[2:0]), .to_status(to_status3),
`endif
    .vld_out(vld_out3), .fifo_full(fifo_full3), .write_enb(write_enb3),
    .soft_reset(soft_reset3), .addr_err(addr_err3)
  );

`ifndef ROUTER_SYNC_TO_STATUS_EN
  assign to_status  = 4'b0000;
  assign to_status3 = 3'b000;
`endif

  function automatic logic [15:0] actual(int kind);
    case (kind)
      0:       return 16'(vld_out);
      1:       return 16'(fifo_full);
      2:       return 16'(write_enb);
      3:       return 16'(soft_reset);
      4:       return 16'(addr_err);
      5:       return 16'(to_status);
      6:       return 16'(addr_err3);
      7:       return 16'(write_enb3);
      8:       return 16'(fifo_full3);
      default: return 16'hdead;
    endcase
  endfunction

  // Monitor: pops expectations due this cycle, and matches every soft_reset pulse.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      chk_t c;
      logic [15:0] a;
      c = sb_q.pop_front();
      a = actual(c.kind);
      n_check++;
      if (c.cyc != cyc || a !== c.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got %h expected %h (due cyc %0d)", c.nm, cyc, a, c.val, c.cyc);
      end
    end
    if (soft_reset != 4'b0000) begin
      n_check++;
      if (pulse_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d: got %b expected 0000", cyc, soft_reset);
      end else begin
        int ec;
        ec = pulse_q.pop_front();
        if (ec != cyc || soft_reset !== 4'b1000) begin
          n_fail++;
          $display("FAIL pulse cyc=%0d: got %b expected 1000 at cyc %0d", cyc, soft_reset, ec);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(int kind, logic [15:0] val, string nm);
    chk_t c;
    c.cyc  = cyc;
    c.kind = kind;
    c.val  = val;
    c.nm   = nm;
    sb_q.push_back(c);
  endtask

  // Idle channel 3 with a read on idle-cycle index r+1; next pulse comes 30 cycles after it.
  task automatic read_run(int r);
    int c;
    step();
    empty    = 4'b0111;
    read_enb = 4'b0000;
    c        = cyc;
    pulse_q.push_back(c + r + 31);
    for (int k = 1; k <= r + 32; k++) begin
      step();
      if (k == r)      read_enb = 4'b1000;
      if (k == r + 1)  read_enb = 4'b0000;
      if (k == 30)     expect_now(3, 16'h0, "no_pulse_after_read");
      if (k == r + 32) empty = 4'b1111;
    end
  endtask

  initial begin
    int c0;
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
    read_enb = 4'b0000; full = 4'b0001; empty = 4'b1111; to_clr = 4'b0000;

    // Reset state
    step();
    expect_now(0, 16'h0, "rst_vld_out");
    expect_now(2, 16'h0, "rst_write_enb");
    expect_now(3, 16'h0, "rst_soft_reset");
    expect_now(4, 16'h0, "rst_addr_err");
    expect_now(1, 16'h1, "rst_fifo_full");

    // Capture address 2; steering follows one cycle later
    step();
    resetn = 1'b1; full = 4'b0000; detect_add = 1'b1; data_in = 2'd2;
    expect_now(2, 16'h0, "we_before_capture");
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 4'b0100;
    expect_now(2, 16'h4, "we_addr2");
    expect_now(1, 16'h1, "fifo_full_addr2");
    step();
    full = 4'b1011;
    expect_now(1, 16'h0, "fifo_full_addr2_clr");

    // Same-cycle capture uses the old address
    step();
    detect_add = 1'b1; data_in = 2'd1;
    expect_now(2, 16'h4, "we_old_addr");
    step();
    detect_add = 1'b0;
    expect_now(2, 16'h2, "we_new_addr1");
    expect_now(1, 16'h1, "fifo_full_addr1");
    step();
    write_enb_reg = 1'b0;
    expect_now(2, 16'h0, "we_no_req");

    // Out-of-range destination on the 3-channel instance
    step();
    detect_add = 1'b1; data_in = 2'd3; write_enb_reg = 1'b1;
    step();
    detect_add = 1'b0;
    expect_now(6, 16'h1, "n3_addr_err");
    expect_now(7, 16'h0, "n3_we_blocked");
    expect_now(8, 16'h1, "n3_fifo_full_err");
    expect_now(2, 16'h8, "n4_we_addr3");
    step();
    detect_add = 1'b1; data_in = 2'd0; full = 4'b0000;
    step();
    detect_add = 1'b0;
    expect_now(6, 16'h0, "n3_addr_ok");
    expect_now(7, 16'h1, "n3_we_addr0");
    expect_now(8, 16'h0, "n3_fifo_full_ok");
    step();
    write_enb_reg = 1'b0;

    // Timeout on channel 3: pulses 30 and 60 cycles after idling starts
    step();
    empty = 4'b0111; read_enb = 4'b0000;
    c0 = cyc;
    expect_now(0, 16'h8, "vld_out_ch3");
    pulse_q.push_back(c0 + 30);
    pulse_q.push_back(c0 + 60);
    for (int k = 1; k <= 61; k++) begin
      step();
      if (k == 31) expect_now(3, 16'h0, "pulse_one_cycle");
`ifdef ROUTER_SYNC_TO_STATUS_EN
      if (k == 30) expect_now(5, 16'h8, "status_set");
      if (k == 35) expect_now(5, 16'h8, "status_sticky");
      if (k == 40) to_clr = 4'b1000;
      if (k == 41) begin to_clr = 4'b0000; expect_now(5, 16'h0, "status_cleared"); end
      if (k == 59) to_clr = 4'b1000;
      if (k == 60) begin to_clr = 4'b0000; expect_now(5, 16'h8, "status_set_wins"); end
`endif
      if (k == 61) empty = 4'b1111;
    end

    read_run(28);
    read_run(29);

    // Reset mid-count clears the counter with nothing pending
    step();
    empty = 4'b0111;
    c0 = cyc;
    pulse_q.push_back(c0 + 51);
    for (int k = 1; k <= 52; k++) begin
      step();
      if (k == 20) begin
        resetn = 1'b0;
        expect_now(3, 16'h0, "soft_reset_in_reset");
`ifdef ROUTER_SYNC_TO_STATUS_EN
        expect_now(5, 16'h0, "status_reset");
`endif
      end
      if (k == 21) resetn = 1'b1;
      if (k == 30) expect_now(3, 16'h0, "no_pulse_after_reset");
      if (k == 52) empty = 4'b1111;
    end

    repeat (5) step();
    while (sb_q.size() > 0) begin
      chk_t c;
      c = sb_q.pop_front();
      n_check++;
      n_fail++;
      $display("FAIL %s: got unchecked expected %h", c.nm, c.val);
    end
    while (pulse_q.size() > 0) begin
      int ec;
      ec = pulse_q.pop_front();
      n_check++;
      n_fail++;
      $display("FAIL missing_pulse: got none expected pulse at cyc %0d", ec);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
